// File: rtl/operand_fetch_stage.sv
// Operand fetch and ID/EX pipeline register: r15 substitution, M/W forwarding,
// RAW interlock detection with bubble insertion and a saturating stall counter.
module operand_fetch_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // decode slot
   input  logic          valid_d,
   input  logic [3:0]    ra1_d,
   input  logic [3:0]    ra2_d,
   input  logic          use_ra1_d,
   input  logic          use_ra2_d,
   input  logic [3:0]    wa_d,
   input  logic          reg_write_d,
   input  logic          mem_to_reg_d,
   input  logic [DW-1:0] pc_plus8_d,
   // register file read port
   output logic [3:0]    ra1,
   output logic [3:0]    ra2,
   input  logic [DW-1:0] rd1,
   input  logic [DW-1:0] rd2,
   // M-stage producer
   input  logic [3:0]    wa_m,
   input  logic          reg_write_m,
   input  logic          mem_to_reg_m,
   input  logic [DW-1:0] alu_result_m,
   // W-stage producer
   input  logic [3:0]    wa_w,
   input  logic          reg_write_w,
   input  logic [DW-1:0] result_w,
   // pipeline control
   input  logic          flush_e,
   output logic          stall_d,
   // ID/EX register
   output logic          valid_e,
   output logic          reg_write_e,
   output logic          mem_to_reg_e,
   output logic [3:0]    wa_e,
   output logic [DW-1:0] srca_e,
   output logic [DW-1:0] srcb_e,
   output logic [CW-1:0] stall_count
);

   localparam logic [3:0] PcReg = 4'd15;

   logic          live1, live2;
   logic          conflict1, conflict2;
   logic          load_e;
   logic [DW-1:0] src1, src2;

   assign ra1 = ra1_d;
   assign ra2 = ra2_d;

   // Operand select; r15 is never forwarded and M wins over W.
   always_comb begin
      src1 = rd1;
      if (ra1_d == PcReg) begin
         src1 = pc_plus8_d;
      end else if (reg_write_m && !mem_to_reg_m && (wa_m == ra1_d)) begin
         src1 = alu_result_m;
      end else if (reg_write_w && (wa_w == ra1_d)) begin
         src1 = result_w;
      end
   end

   always_comb begin
      src2 = rd2;
      if (ra2_d == PcReg) begin
         src2 = pc_plus8_d;
      end else if (reg_write_m && !mem_to_reg_m && (wa_m == ra2_d)) begin
         src2 = alu_result_m;
      end else if (reg_write_w && (wa_w == ra2_d)) begin
         src2 = result_w;
      end
   end

   // A load in M has no data yet, so it interlocks like an E producer.
   always_comb begin
      live1     = valid_d && use_ra1_d && (ra1_d != PcReg);
      live2     = valid_d && use_ra2_d && (ra2_d != PcReg);
      conflict1 = (valid_e && reg_write_e && (wa_e == ra1_d)) ||
                  (reg_write_m && mem_to_reg_m && (wa_m == ra1_d));
      conflict2 = (valid_e && reg_write_e && (wa_e == ra2_d)) ||
                  (reg_write_m && mem_to_reg_m && (wa_m == ra2_d));
      stall_d   = (live1 && conflict1) || (live2 && conflict2);
      load_e    = !(flush_e || stall_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_e      <= 1'b0;
         reg_write_e  <= 1'b0;
         mem_to_reg_e <= 1'b0;
         wa_e         <= '0;
         srca_e       <= '0;
         srcb_e       <= '0;
      end else if (load_e) begin
         valid_e      <= valid_d;
         reg_write_e  <= reg_write_d & valid_d;
         mem_to_reg_e <= mem_to_reg_d & valid_d;
         wa_e         <= wa_d;
         srca_e       <= src1;
         srcb_e       <= src2;
      end else begin
         // Bubble: kill controls, leave the datapath fields untouched.
         valid_e      <= 1'b0;
         reg_write_e  <= 1'b0;
         mem_to_reg_e <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall_d && (stall_count != '1)) begin
         stall_count <= stall_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus randomized
// traffic compared against a register-set reference model.
module tb_operand_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        valid_d;
   logic [3:0]  ra1_d, ra2_d;
   logic        use_ra1_d, use_ra2_d;
   logic [3:0]  wa_d;
   logic        reg_write_d, mem_to_reg_d;
   logic [31:0] pc_plus8_d;
   logic [3:0]  ra1, ra2;
   logic [31:0] rd1, rd2;
   logic [3:0]  wa_m;
   logic        reg_write_m, mem_to_reg_m;
   logic [31:0] alu_result_m;
   logic [3:0]  wa_w;
   logic        reg_write_w;
   logic [31:0] result_w;
   logic        flush_e;
   logic        stall_d;
   logic        valid_e, reg_write_e, mem_to_reg_e;
   logic [3:0]  wa_e;
   logic [31:0] srca_e, srcb_e;
   logic [15:0] stall_count;

   logic [3:0]  sat_ra1, sat_ra2;
   logic        sat_stall_d;
   logic        sat_valid_e, sat_reg_write_e, sat_mem_to_reg_e;
   logic [3:0]  sat_wa_e;
   logic [31:0] sat_srca_e, sat_srcb_e;
   logic [1:0]  sat_stall_count;

   int checks = 0;
   int errors = 0;

   operand_fetch_stage #(.DW(32), .CW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ra1_d(ra1_d), .ra2_d(ra2_d),
      .use_ra1_d(use_ra1_d), .use_ra2_d(use_ra2_d), .wa_d(wa_d),
      .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .pc_plus8_d(pc_plus8_d),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .wa_m(wa_m), .reg_write_m(reg_write_m),
      .mem_to_reg_m(mem_to_reg_m), .alu_result_m(alu_result_m), .wa_w(wa_w),
      .reg_write_w(reg_write_w), .result_w(result_w), .flush_e(flush_e), .stall_d(stall_d),
      .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
      .wa_e(wa_e), .srca_e(srca_e), .srcb_e(srcb_e), .stall_count(stall_count)
   );

   operand_fetch_stage #(.DW(32), .CW(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ra1_d(ra1_d), .ra2_d(ra2_d),
      .use_ra1_d(use_ra1_d), .use_ra2_d(use_ra2_d), .wa_d(wa_d),
      .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .pc_plus8_d(pc_plus8_d),
      .ra1(sat_ra1), .ra2(sat_ra2), .rd1(rd1), .rd2(rd2), .wa_m(wa_m),
      .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .alu_result_m(alu_result_m),
      .wa_w(wa_w), .reg_write_w(reg_write_w), .result_w(result_w), .flush_e(flush_e),
      .stall_d(sat_stall_d), .valid_e(sat_valid_e), .reg_write_e(sat_reg_write_e),
      .mem_to_reg_e(sat_mem_to_reg_e), .wa_e(sat_wa_e), .srca_e(sat_srca_e),
      .srcb_e(sat_srcb_e), .stall_count(sat_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      valid_d = 0; ra1_d = 0; ra2_d = 0; use_ra1_d = 0; use_ra2_d = 0; wa_d = 0;
      reg_write_d = 0; mem_to_reg_d = 0; pc_plus8_d = 0; rd1 = 0; rd2 = 0;
      wa_m = 0; reg_write_m = 0; mem_to_reg_m = 0; alu_result_m = 0;
      wa_w = 0; reg_write_w = 0; result_w = 0; flush_e = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 0;
      #2;
      rst_n = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      valid_d = 1; wa_d = 7; reg_write_d = 1; mem_to_reg_d = 1;
      ra1_d = 2; use_ra1_d = 1; rd1 = 32'hDEAD;
      step();
      reg_write_m = 1; mem_to_reg_m = 1; wa_m = 2;
      step();
      checks++;
      if (stall_count !== 16'd1) begin
         errors++; $display("FAIL pre_reset_count got %0d exp 1", stall_count);
      end
      #2;
      clear_inputs();
      rst_n = 0;
      #1;
      checks++;
      if ({valid_e, reg_write_e, mem_to_reg_e, wa_e, srca_e, srcb_e, stall_count, stall_d}
          !== '0) begin
         errors++;
         $display("FAIL async_reset got v%b rw%b m%b wa%h a%h b%h c%h s%b exp all zero",
                  valid_e, reg_write_e, mem_to_reg_e, wa_e, srca_e, srcb_e, stall_count,
                  stall_d);
      end
      @(negedge clk);
      rst_n = 1;
      valid_d = 1; ra1_d = 2; use_ra1_d = 1; rd1 = 32'h11;
      step();
      checks++;
      if (srca_e !== 32'h11 || valid_e !== 1'b1) begin
         errors++; $display("FAIL post_reset_load got a=%h v=%b exp a=11 v=1", srca_e, valid_e);
      end
   endtask

   task automatic test_r15();
      clear_inputs();
      valid_d = 1; ra1_d = 15; use_ra1_d = 1; pc_plus8_d = 32'h108; rd1 = 32'h55;
      reg_write_w = 1; wa_w = 15; result_w = 32'hBAD;
      reg_write_m = 1; wa_m = 15; alu_result_m = 32'hBEEF;
      #1;
      checks++;
      if (stall_d !== 1'b0) begin
         errors++; $display("FAIL r15_stall got %b exp 0", stall_d);
      end
      step();
      checks++;
      if (srca_e !== 32'h108) begin
         errors++; $display("FAIL r15_operand got %h exp 108", srca_e);
      end
   endtask

   task automatic test_w_bypass();
      clear_inputs();
      valid_d = 1; ra2_d = 3; use_ra2_d = 1; rd2 = 0;
      reg_write_w = 1; wa_w = 3; result_w = 32'hAAAA5555;
      step();
      checks++;
      if (srcb_e !== 32'hAAAA5555) begin
         errors++; $display("FAIL w_bypass got %h exp aaaa5555", srcb_e);
      end
      // Same register in M and W, read by both sources: M wins on each.
      ra1_d = 3; use_ra1_d = 1; rd1 = 32'h1;
      reg_write_m = 1; wa_m = 3; alu_result_m = 32'h1234;
      step();
      checks++;
      if (srca_e !== 32'h1234 || srcb_e !== 32'h1234) begin
         errors++; $display("FAIL m_over_w got a=%h b=%h exp 1234", srca_e, srcb_e);
      end
   endtask

   task automatic test_alu_b2b();
      apply_reset();
      clear_inputs();
      valid_d = 1; wa_d = 4; reg_write_d = 1;
      step();
      clear_inputs();
      valid_d = 1; ra1_d = 4; use_ra1_d = 1; rd1 = 32'h99;
      #1;
      checks++;
      if (stall_d !== 1'b1) begin
         errors++; $display("FAIL alu_stall got %b exp 1", stall_d);
      end
      step();
      checks++;
      if (valid_e !== 1'b0) begin
         errors++; $display("FAIL alu_bubble got %b exp 0", valid_e);
      end
      reg_write_m = 1; wa_m = 4; alu_result_m = 32'h7;
      #1;
      checks++;
      if (stall_d !== 1'b0) begin
         errors++; $display("FAIL alu_release got %b exp 0", stall_d);
      end
      step();
      checks++;
      if (srca_e !== 32'h7 || valid_e !== 1'b1 || stall_count !== 16'd1) begin
         errors++;
         $display("FAIL alu_forward got a=%h v=%b c=%0d exp a=7 v=1 c=1",
                  srca_e, valid_e, stall_count);
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      clear_inputs();
      valid_d = 1; wa_d = 5; reg_write_d = 1; mem_to_reg_d = 1;
      step();
      clear_inputs();
      valid_d = 1; ra2_d = 5; use_ra2_d = 1; rd2 = 32'h77;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (stall_d !== 1'b1) begin
            errors++; $display("FAIL load_stall_%0d got %b exp 1", i, stall_d);
         end
         step();
         checks++;
         if (valid_e !== 1'b0) begin
            errors++; $display("FAIL load_bubble_%0d got %b exp 0", i, valid_e);
         end
         if (i == 0) begin
            reg_write_m = 1; wa_m = 5; mem_to_reg_m = 1;
         end
      end
      reg_write_m = 0; mem_to_reg_m = 0; wa_m = 0;
      reg_write_w = 1; wa_w = 5; result_w = 32'hC0FFEE;
      #1;
      checks++;
      if (stall_d !== 1'b0) begin
         errors++; $display("FAIL load_release got %b exp 0", stall_d);
      end
      step();
      checks++;
      if (srcb_e !== 32'hC0FFEE || valid_e !== 1'b1 || stall_count !== 16'd2) begin
         errors++;
         $display("FAIL load_forward got b=%h v=%b c=%0d exp b=c0ffee v=1 c=2",
                  srcb_e, valid_e, stall_count);
      end
   endtask

   task automatic test_flush();
      clear_inputs();
      valid_d = 1; wa_d = 9; reg_write_d = 1; mem_to_reg_d = 1; flush_e = 1;
      step();
      checks++;
      if ({valid_e, reg_write_e, mem_to_reg_e} !== 3'b000) begin
         errors++;
         $display("FAIL flush_kill got v%b rw%b m%b exp 000", valid_e, reg_write_e, mem_to_reg_e);
      end
      // Stall is still raised while flushing and still counted.
      ra1_d = 6; use_ra1_d = 1; reg_write_m = 1; mem_to_reg_m = 1; wa_m = 6;
      #1;
      checks++;
      if (stall_d !== 1'b1) begin
         errors++; $display("FAIL flush_stall got %b exp 1", stall_d);
      end
      step();
      checks++;
      if (stall_count !== 16'd3 || valid_e !== 1'b0) begin
         errors++; $display("FAIL flush_count got c=%0d v=%b exp c=3 v=0", stall_count, valid_e);
      end
      flush_e = 0;
   endtask

   task automatic test_saturation();
      apply_reset();
      clear_inputs();
      valid_d = 1; ra1_d = 1; use_ra1_d = 1;
      reg_write_m = 1; mem_to_reg_m = 1; wa_m = 1;
      repeat (5) step();
      checks++;
      if (sat_stall_count !== 2'd3) begin
         errors++; $display("FAIL sat_count got %0d exp 3", sat_stall_count);
      end
      checks++;
      if (stall_count !== 16'd5) begin
         errors++; $display("FAIL wide_count got %0d exp 5", stall_count);
      end
   endtask

   function automatic logic [3:0] rand_reg();
      int unsigned r;
      r = $urandom_range(0, 7);
      return (r > 5) ? 4'd15 : 4'(r);
   endfunction

   // Reference operand: value the architectural register holds as seen from D.
   function automatic logic [31:0] ref_operand(input logic [3:0] ra, input logic [31:0] rd);
      if (ra == 4'd15) return pc_plus8_d;
      if (reg_write_m && !mem_to_reg_m && wa_m == ra) return alu_result_m;
      if (reg_write_w && wa_w == ra) return result_w;
      return rd;
   endfunction

   task automatic test_random();
      logic        m_valid, m_rw, m_m2r;
      logic [3:0]  m_wa;
      logic [31:0] m_a, m_b;
      logic [15:0] m_cnt;
      logic [15:0] pending;
      logic        exp_stall;
      apply_reset();
      m_valid = 0; m_rw = 0; m_m2r = 0; m_wa = 0; m_a = 0; m_b = 0; m_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         valid_d = ($urandom_range(0, 4) != 0);
         ra1_d = rand_reg(); ra2_d = rand_reg(); wa_d = rand_reg();
         use_ra1_d = $urandom_range(0, 1) == 1; use_ra2_d = $urandom_range(0, 1) == 1;
         reg_write_d = $urandom_range(0, 1) == 1; mem_to_reg_d = $urandom_range(0, 1) == 1;
         pc_plus8_d = $urandom; rd1 = $urandom; rd2 = $urandom;
         wa_m = rand_reg(); reg_write_m = $urandom_range(0, 1) == 1;
         mem_to_reg_m = $urandom_range(0, 2) == 0; alu_result_m = $urandom;
         wa_w = rand_reg(); reg_write_w = $urandom_range(0, 1) == 1; result_w = $urandom;
         flush_e = ($urandom_range(0, 7) == 0);
         #1;
         // Registers whose value is not yet available to D.
         pending = '0;
         if (m_valid && m_rw) pending[m_wa] = 1'b1;
         if (reg_write_m && mem_to_reg_m) pending[wa_m] = 1'b1;
         exp_stall = valid_d && ((use_ra1_d && ra1_d != 15 && pending[ra1_d]) ||
                                 (use_ra2_d && ra2_d != 15 && pending[ra2_d]));
         checks++;
         if (stall_d !== exp_stall || ra1 !== ra1_d || ra2 !== ra2_d) begin
            errors++;
            $display("FAIL rand_comb[%0d] got s=%b r1=%h r2=%h exp s=%b r1=%h r2=%h",
                     i, stall_d, ra1, ra2, exp_stall, ra1_d, ra2_d);
         end
         if (flush_e || exp_stall) begin
            m_valid = 0; m_rw = 0; m_m2r = 0;
         end else begin
            m_valid = valid_d; m_rw = reg_write_d && valid_d; m_m2r = mem_to_reg_d && valid_d;
            m_wa = wa_d; m_a = ref_operand(ra1_d, rd1); m_b = ref_operand(ra2_d, rd2);
         end
         if (exp_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
         step();
         checks++;
         if ({valid_e, reg_write_e, mem_to_reg_e, wa_e, srca_e, srcb_e}
             !== {m_valid, m_rw, m_m2r, m_wa, m_a, m_b}) begin
            errors++;
            $display("FAIL rand_e[%0d] got v%b rw%b m%b wa%h a%h b%h exp v%b rw%b m%b wa%h a%h b%h",
                     i, valid_e, reg_write_e, mem_to_reg_e, wa_e, srca_e, srcb_e,
                     m_valid, m_rw, m_m2r, m_wa, m_a, m_b);
         end
         checks++;
         if (stall_count !== m_cnt) begin
            errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", i, stall_count, m_cnt);
         end
      end
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      #12;
      rst_n = 1;
      test_reset();
      test_r15();
      test_w_bypass();
      test_alu_b2b();
      test_load_use();
      test_flush();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-side operand fetch and ID/EX pipeline register for the 5-stage CPU, sitting between decode and the register file on one side and the execute stage on the other. The block drives the register-file read addresses and bypasses the write-back result, because the register file writes on the clock edge and reads combinationally. It substitutes PC+8 for r15 and forwards from the M and W stages. It detects read-after-write interlocks, stalls decode, inserts bubbles, and keeps a saturating stall-cycle counter.

## Interface
- DW, 32, datapath width
- CW, 16, stall counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_d  in  1  decode slot holds a real instruction
- ra1_d, ra2_d  in  4  source register numbers
- use_ra1_d, use_ra2_d  in  1  source actually read by the instruction
- wa_d  in  4  destination register
- reg_write_d, mem_to_reg_d  in  1  control bits of the decode instruction
- pc_plus8_d  in  DW  value read as r15
- ra1, ra2  out  4  register-file read addresses, equal to ra1_d/ra2_d combinationally
- rd1, rd2  in  DW  register-file read data
- wa_m, reg_write_m, mem_to_reg_m  in  4/1/1  M-stage producer
- alu_result_m  in  DW  M-stage ALU result
- wa_w, reg_write_w  in  4/1  W-stage producer; the same values drive the register-file write port
- result_w  in  DW  W-stage write data
- flush_e  in  1  kill the instruction entering E
- stall_d  out  1  hold F/D this cycle (combinational)
- valid_e, reg_write_e, mem_to_reg_e  out  1  registered controls
- wa_e  out  4  registered destination
- srca_e, srcb_e  out  DW  registered operands
- stall_count  out  CW  saturating count of stall cycles

## Operation
- **Operand select per source** (n = 1, 2), first match wins:
  1. ra_n == 15 → pc_plus8_d.
  2. reg_write_m && wa_m == ra_n && !mem_to_reg_m → alu_result_m.
  3. reg_write_w && wa_w == ra_n → result_w.
  4. Otherwise → rd_n.
- Forwarding never applies to r15, even if wa_m or wa_w is 15.
- **Hazard.** A source is "live" when valid_d && use_ra_n_d && ra_n_d != 15. stall_d = 1 when either of these holds:
  - (E conflict) valid_e && reg_write_e && wa_e == a live source.
  - (M load conflict) reg_write_m && mem_to_reg_m && wa_m == a live source.
- Effective interlock cost: 1 stall cycle for an ALU producer directly ahead, 2 for a load directly ahead.
- **ID/EX register update** on each clock edge:
  - If flush_e or stall_d: bubble. valid_e, reg_write_e and mem_to_reg_e go to 0; wa_e, srca_e and srcb_e hold their previous values.
  - Otherwise: load valid_d, wa_d, the selected operands, and the control bits ANDed with valid_d.
- flush_e takes priority over the load. stall_d is still computed normally during flush_e and is not masked.
- **stall_count** increments by 1 on each edge where stall_d = 1. It saturates at 2^CW−1 and never wraps.

## Timing
- Reset (asynchronous, rst_n = 0): valid_e, reg_write_e, mem_to_reg_e, wa_e, srca_e, srcb_e and stall_count all go to 0. stall_d therefore reads 0 until the first valid instruction.
- Reset released mid-stall: the in-flight instruction is lost. No state survives reset.
- Latency: a D-stage operand appears on srca_e/srcb_e 1 cycle after the edge it is captured on. ra1/ra2 have zero latency.
- Write-back in the same cycle as the read: result_w is selected, so the stale rd_n is never latched.
- Same register in both M and W: the M value wins. Same register in both sources: each source resolves independently.
- Upstream holds the F/D contents for every cycle stall_d = 1. The block does not latch decode inputs.

## Test plan
- Reset: drive rst_n = 0 mid-cycle → all outputs 0 immediately (asynchronous). After release, valid_d = 1, ra1 = 2 with rd1 = 0x11 → next cycle srca_e = 0x11, valid_e = 1.
- r15 read: ra1_d = 15, pc_plus8_d = 0x108, with reg_write_w = 1 and wa_w = 15 → srca_e = 0x108, stall_d = 0.
- W bypass: wa_w = 3, result_w = 0xAAAA5555, rd2 = 0 stale, ra2_d = 3 → srcb_e = 0xAAAA5555.
- ALU back-to-back: E holds reg_write_e = 1, wa_e = 4; D reads r4 → stall_d = 1 for 1 cycle and a bubble appears in E. Next cycle the producer is in M with alu_result_m = 0x7 → srca_e = 0x7, stall_count = 1.
- Load-use: E holds a load to r5; D reads r5 → stall_d = 1 for exactly 2 cycles, 2 bubbles in E, then the operand equals result_w. stall_count increases by 2.
- Flush plus saturation: flush_e = 1 with a valid D instruction → valid_e = 0 and reg_write_e = 0. Separately, with CW = 2, hold a hazard for 5 cycles → stall_count = 3.
